// File: rtl/cache_bus_ctrl.sv
// cache_bus_ctrl: direct-mapped, write-through, read-allocate cache
// controller with bus direction control, ack timeout and hit counter.
module cache_bus_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_rw,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        hit_cnt
);
    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wait_q, wait_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    logic [DATA_W-1:0] rdata_d;
    logic              ready_d;
    logic              err_d;
    logic              req_d;
    logic              rw_d;
    logic              oe_d;
    logic [ADDR_W-1:0] maddr_d;
    logic [DATA_W-1:0] mwdata_d;
    logic [7:0]        hit_d;

    logic              line_we;
    logic [DATA_W-1:0] line_data;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              expired;
    logic [7:0]        hit_inc;

    assign idx     = addr_q[IDX_W-1:0];
    assign tag     = addr_q[ADDR_W-1:IDX_W];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign expired = (wait_q == 8'(TIMEOUT - 1));
    assign hit_inc = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        valid_d   = valid_q;
        rdata_d   = cpu_rdata;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        req_d     = mem_req;
        rw_d      = mem_rw;
        oe_d      = mem_oe;
        maddr_d   = mem_addr;
        mwdata_d  = mem_wdata;
        hit_d     = hit_cnt;
        line_we   = 1'b0;
        line_data = wdata_q;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_d = LOOKUP;
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                end
            end
            LOOKUP: begin
                wait_d = '0;
                unique case (1'b1)
                    we_q: begin
                        state_d  = MEM_WR;
                        req_d    = 1'b1;
                        rw_d     = 1'b0;
                        oe_d     = 1'b1;
                        maddr_d  = addr_q;
                        mwdata_d = wdata_q;
                        if (hit) begin
                            line_we = 1'b1;
                            hit_d   = hit_inc;
                        end
                    end
                    (!we_q && hit): begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        rdata_d = data_q[idx];
                        hit_d   = hit_inc;
                    end
                    default: begin
                        state_d = MEM_RD;
                        req_d   = 1'b1;
                        rw_d    = 1'b1;
                        oe_d    = 1'b0;
                        maddr_d = addr_q;
                    end
                endcase
            end
            MEM_RD, MEM_WR: begin
                // ack wins over expiry on the same edge
                if (mem_ack || expired) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    req_d   = 1'b0;
                    oe_d    = 1'b0;
                    rw_d    = 1'b1;
                    if (!mem_ack) begin
                        err_d = 1'b1;
                    end else if (state == MEM_RD) begin
                        valid_d[idx] = 1'b1;
                        line_we      = 1'b1;
                        line_data    = mem_rdata;
                        rdata_d      = mem_rdata;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wait_q    <= '0;
            valid_q   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_rw    <= 1'b1;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            valid_q   <= valid_d;
            cpu_rdata <= rdata_d;
            cpu_ready <= ready_d;
            cpu_err   <= err_d;
            mem_req   <= req_d;
            mem_rw    <= rw_d;
            mem_oe    <= oe_d;
            mem_addr  <= maddr_d;
            mem_wdata <= mwdata_d;
            hit_cnt   <= hit_d;
        end
    end

    // tag/data storage is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_data;
        end
    end

endmodule
